// File: rtl/uart_tx_frame_serializer.sv
// rtl/uart_tx_frame_serializer.sv - UART transmit frame serializer
//
// Purpose:
//   Serializes one DATA_WIDTH-bit word per frame onto TX_OUT as
//   start(0), data LSB first, optional parity, stop(1). Every bit lasts
//   exactly `prescale` clocks of clk_based_on_prescale, so the line matches
//   a receiver running on the same oversampled clock and prescale.
//
// Ports:
//   clk_based_on_prescale  in   oversampled clock (prescale x baud)
//   asy_reset              in   asynchronous reset, active low
//   P_DATA                 in   word to send, latched at accept
//   data_valid             in   send request, accepted only while idle
//   parity_enable          in   1 = parity bit after the data bits
//   parity_type            in   0 = even, 1 = odd
//   prescale               in   clocks per bit: 8, 16 or 32 (others -> 8)
//   TX_OUT                 out  registered serial line, idles high
//   busy                   out  registered, high while a frame is in flight
//   tx_done                out  one-cycle pulse after the last stop bit
//
// Build option:
//   UART_TX_TWO_STOP_EN - when defined, the stop phase lasts two bit periods.

module uart_tx_frame_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk_based_on_prescale,
   input  logic                  asy_reset,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  data_valid,
   input  logic                  parity_enable,
   input  logic                  parity_type,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  TX_OUT,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] data_reg, data_nxt;
   logic                  par_bit, par_bit_nxt;
   logic                  par_en, par_en_nxt;
   logic [PRESCALE_W-1:0] cnt_last, cnt_last_nxt;
   logic [PRESCALE_W-1:0] edge_cnt, edge_cnt_nxt;
   logic [IDX_W-1:0]      bit_idx, bit_idx_nxt;
   logic                  tx_nxt, busy_nxt, done_nxt;
   logic                  bit_end;
   logic                  stop_last;
   logic [PRESCALE_W-1:0] pre_sel;

   // Unsupported prescale values fall back to 8 so a bad setting still
   // produces a well-formed frame instead of a stuck or runaway counter.
   assign pre_sel = (prescale == PRESCALE_W'(16) || prescale == PRESCALE_W'(32)) ?
                    prescale : PRESCALE_W'(8);

   // Last clock of the current bit period; the counter holds the latched
   // prescale minus one so the compare is a plain equality.
   assign bit_end = (state != IDLE) && (edge_cnt == cnt_last);

`ifdef UART_TX_TWO_STOP_EN
   logic stop_cnt, stop_cnt_nxt;
   assign stop_last = stop_cnt;
`else
   assign stop_last = 1'b1;
`endif

   always_comb begin
      state_nxt    = state;
      data_nxt     = data_reg;
      par_bit_nxt  = par_bit;
      par_en_nxt   = par_en;
      cnt_last_nxt = cnt_last;
      bit_idx_nxt  = bit_idx;
      tx_nxt       = TX_OUT;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      edge_cnt_nxt = (state == IDLE || bit_end) ? '0 : edge_cnt + 1'b1;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt_nxt = stop_cnt;
`endif
      case (state)
         IDLE: begin
            tx_nxt = 1'b1;
            // Start bit goes out on the accept edge itself.
            if (data_valid && !busy) begin
               state_nxt    = START;
               data_nxt     = P_DATA;
               par_bit_nxt  = (^P_DATA) ^ parity_type;
               par_en_nxt   = parity_enable;
               cnt_last_nxt = pre_sel - 1'b1;
               tx_nxt       = 1'b0;
               busy_nxt     = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt   = DATA;
               bit_idx_nxt = '0;
               tx_nxt      = data_reg[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == LAST_IDX) begin
                  if (par_en) begin
                     state_nxt = PARITY;
                     tx_nxt    = par_bit;
                  end else begin
                     state_nxt = STOP;
                     tx_nxt    = 1'b1;
                  end
               end else begin
                  bit_idx_nxt = bit_idx + 1'b1;
                  tx_nxt      = data_reg[bit_idx_nxt];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_nxt = STOP;
               tx_nxt    = 1'b1;
            end
         end
         STOP: begin
            tx_nxt = 1'b1;
            if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
               stop_cnt_nxt = ~stop_cnt;
`endif
               if (stop_last) begin
                  state_nxt = IDLE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
      if (!asy_reset) begin
         state    <= IDLE;
         data_reg <= '0;
         par_bit  <= 1'b0;
         par_en   <= 1'b0;
         cnt_last <= '0;
         edge_cnt <= '0;
         bit_idx  <= '0;
         TX_OUT   <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
         stop_cnt <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         data_reg <= data_nxt;
         par_bit  <= par_bit_nxt;
         par_en   <= par_en_nxt;
         cnt_last <= cnt_last_nxt;
         edge_cnt <= edge_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         TX_OUT   <= tx_nxt;
         busy     <= busy_nxt;
         tx_done  <= done_nxt;
`ifdef UART_TX_TWO_STOP_EN
         stop_cnt <= stop_cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// tb/tb_uart_tx_frame_serializer.sv - scoreboard bench for uart_tx_frame_serializer
//
// Purpose: drives directed and random frames, queues the expected line
// waveform per frame and checks it bit by bit from an independent monitor.
// Ports: none (top-level bench).

module tb_uart_tx_frame_serializer;

   logic       clk_based_on_prescale = 1'b0;
   logic       asy_reset;
   logic [7:0] P_DATA;
   logic       data_valid;
   logic       parity_enable;
   logic       parity_type;
   logic [5:0] prescale;
   logic       TX_OUT;
   logic       busy;
   logic       tx_done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] data;
      bit         pe;
      bit         pt;
      int         p;
      bit         b2b;
   } frame_t;

   frame_t exp_q[$];
   bit     expect_start    = 1'b0;
   bit     expect_done_low = 1'b0;

   uart_tx_frame_serializer dut (
      .clk_based_on_prescale (clk_based_on_prescale),
      .asy_reset             (asy_reset),
      .P_DATA                (P_DATA),
      .data_valid            (data_valid),
      .parity_enable         (parity_enable),
      .parity_type           (parity_type),
      .prescale              (prescale),
      .TX_OUT                (TX_OUT),
      .busy                  (busy),
      .tx_done               (tx_done)
   );

   always #5 clk_based_on_prescale = ~clk_based_on_prescale;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   function automatic int eff_p(input logic [5:0] ps);
      if (ps == 6'd16) return 16;
      if (ps == 6'd32) return 32;
      return 8;
   endfunction

   // Called at the negedge where busy was first seen high; walks the whole
   // frame one clock at a time and finishes on the negedge where busy falls.
   task automatic check_frame();
      frame_t     f;
      bit         bits[$];
      logic [2:0] got;
      logic [2:0] want;
      bit         seen;
      if (exp_q.size() == 0) begin
         chk("unexpected_frame", 32'd1, 32'd0);
         for (int n = 0; n < 2000 && busy && asy_reset; n++) @(negedge clk_based_on_prescale);
         return;
      end
      f = exp_q.pop_front();
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(f.data[i]);
      if (f.pe) bits.push_back((^f.data) ^ f.pt);
      bits.push_back(1'b1);
`ifdef UART_TX_TWO_STOP_EN
      bits.push_back(1'b1);
`endif
      for (int b = 0; b < bits.size(); b++) begin
         want = {1'b0, 1'b1, bits[b]};
         got  = 3'bxxx;
         seen = 1'b0;
         for (int c = 0; c < f.p; c++) begin
            if (b != 0 || c != 0) @(negedge clk_based_on_prescale);
            if (!asy_reset) return;
            if (!seen) begin
               got = {tx_done, busy, TX_OUT};
               if (got !== want) seen = 1'b1;
            end
         end
         chk($sformatf("frame_%02h_bit%0d_{done,busy,tx}", f.data, b), got, want);
      end
      @(negedge clk_based_on_prescale);
      if (!asy_reset) return;
      chk($sformatf("frame_%02h_end_{done,busy,tx}", f.data), {tx_done, busy, TX_OUT}, 3'b101);
      expect_done_low = 1'b1;
      expect_start    = (exp_q.size() > 0) && exp_q[0].b2b;
   endtask

   initial begin : monitor
      bit prev_busy;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk_based_on_prescale);
         if (!asy_reset) begin
            prev_busy       = 1'b0;
            expect_start    = 1'b0;
            expect_done_low = 1'b0;
            continue;
         end
         if (expect_done_low) begin
            chk("tx_done_single_cycle", tx_done, 1'b0);
            expect_done_low = 1'b0;
         end
         if (expect_start) begin
            chk("b2b_gap_one_clock", busy, 1'b1);
            expect_start = 1'b0;
         end
         if (busy && !prev_busy) begin
            check_frame();
            prev_busy = 1'b0;
         end else begin
            prev_busy = busy;
         end
      end
   end

   // b2b: request is already high from the previous frame, so do not wait for
   // idle first; hold: leave data_valid high after acceptance.
   task automatic send(input logic [7:0] d, input bit pe, input bit pt,
                       input logic [5:0] ps, input bit b2b, input bit hold);
      frame_t f;
      if (!b2b) begin
         for (int n = 0; n < 2000 && busy; n++) @(negedge clk_based_on_prescale);
      end
      P_DATA        = d;
      parity_enable = pe;
      parity_type   = pt;
      prescale      = ps;
      data_valid    = 1'b1;
      f.data = d;
      f.pe   = pe;
      f.pt   = pt;
      f.p    = eff_p(ps);
      f.b2b  = b2b;
      exp_q.push_back(f);
      for (int n = 0; n < 2000 && busy; n++) @(negedge clk_based_on_prescale);
      if (busy) chk("wait_idle_timeout", 32'd1, 32'd0);
      for (int n = 0; n < 10 && !busy; n++) @(negedge clk_based_on_prescale);
      if (!busy) chk("accept_timeout", 32'd1, 32'd0);
      if (!hold) data_valid = 1'b0;
   endtask

   initial begin : stimulus
      logic [7:0] rd;
      logic [5:0] rps;
      asy_reset     = 1'b0;
      P_DATA        = 8'h00;
      data_valid    = 1'b0;
      parity_enable = 1'b0;
      parity_type   = 1'b0;
      prescale      = 6'd8;
      repeat (3) @(negedge clk_based_on_prescale);
      chk("reset_tx_out", TX_OUT, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_tx_done", tx_done, 1'b0);
      asy_reset = 1'b1;
      @(negedge clk_based_on_prescale);

      send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0);
      send(8'hA5, 1'b1, 1'b0, 6'd16, 1'b0, 1'b0);
      send(8'hA5, 1'b1, 1'b1, 6'd16, 1'b0, 1'b0);
      send(8'h00, 1'b1, 1'b1, 6'd32, 1'b0, 1'b0);

      // New request raised during data bit 3 and held through the end of frame.
      send(8'h3C, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0);
      repeat (34) @(negedge clk_based_on_prescale);
      send(8'hFF, 1'b0, 1'b0, 6'd8, 1'b1, 1'b0);

      // Request pulsed mid-frame and dropped before busy falls: never sent.
      send(8'h12, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0);
      repeat (20) @(negedge clk_based_on_prescale);
      P_DATA     = 8'hFF;
      data_valid = 1'b1;
      repeat (5) @(negedge clk_based_on_prescale);
      data_valid = 1'b0;

      send(8'h55, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1);
      send(8'hAA, 1'b0, 1'b0, 6'd8, 1'b1, 1'b0);

      // Reset asserted during data bit 4.
      send(8'h5A, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0);
      repeat (42) @(negedge clk_based_on_prescale);
      #2 asy_reset = 1'b0;
      #1;
      chk("midreset_tx_out", TX_OUT, 1'b1);
      chk("midreset_busy", busy, 1'b0);
      chk("midreset_tx_done", tx_done, 1'b0);
      repeat (3) @(negedge clk_based_on_prescale);
      #2 asy_reset = 1'b1;
      @(negedge clk_based_on_prescale);
      chk("idle_after_reset", {busy, TX_OUT}, 2'b01);
      send(8'h81, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0);

      for (int k = 0; k < 12; k++) begin
         rd = 8'($urandom);
         case ($urandom_range(0, 3))
            0:       rps = 6'd8;
            1:       rps = 6'd16;
            2:       rps = 6'd32;
            default: rps = 6'($urandom_range(0, 63));
         endcase
         send(rd, 1'($urandom), 1'($urandom), rps, 1'b0, 1'b0);
         // Scramble the inputs mid-frame; they must have no effect.
         P_DATA        = 8'($urandom);
         parity_enable = 1'($urandom);
         parity_type   = 1'($urandom);
         prescale      = 6'($urandom);
      end

      for (int n = 0; n < 3000 && (exp_q.size() > 0 || busy); n++) @(negedge clk_based_on_prescale);
      chk("drain_queue_empty", exp_q.size(), 32'd0);
      chk("drain_idle", busy, 1'b0);
      repeat (4) @(negedge clk_based_on_prescale);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
